// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the frame serializer: FSM state encoding,
// parity-mode constants and the parity helper.
package frame_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Even parity is the XOR of the word; odd parity is its inverse.
  function automatic logic parityBit(input logic wordXor, input int mode);
    return (mode == PAR_ODD) ? ~wordXor : wordXor;
  endfunction

endpackage

// File: rtl/frame_serializer_bit_tick_divider.sv
// Symbol-period divider: counts 0..DIV-1 while run is high and flags the
// last cycle of every symbol period with tick.
module bit_tick_divider #(
  parameter int DIV   = 1,
  parameter int DIV_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  logic [DIV_W-1:0] count;

  assign tick = run && (count == DIV_W'(DIV - 1));

  // Count is held at zero whenever no frame is running, so every frame
  // starts with a full-length first symbol.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: accepts a WIDTH-bit word on a valid/ready handshake and
// shifts it out on tx_d with optional start/stop framing and parity.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter int DIV       = 1,
  parameter int DIV_W     = 4,
  parameter int MSB_FIRST = 0,
  parameter int FRAMED    = 0,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             tx_d,
  output logic             tx_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam bit HAS_PARITY = (PARITY != PAR_NONE);
  localparam bit HAS_FRAME  = (FRAMED != 0);
  localparam bit MSB_ORDER  = (MSB_FIRST != 0);

  txState_e         state;
  logic [WIDTH-1:0] shiftReg;
  logic [IDX_W-1:0] bitIdx;
  logic             parityReg;
  logic             symbolTick;
  logic             frameActive;
  logic             firstDataBit;
  logic             headBit;
  logic             nextBit;
  logic [WIDTH-1:0] shiftNext;

  assign frameActive = (state != ST_IDLE);
  assign tx_busy     = ~tx_ready;

  // The word is physically shifted towards the outgoing end, so the bit on
  // the wire is always taken from a fixed position of the shift register.
  assign firstDataBit = MSB_ORDER ? data_in[WIDTH-1]  : data_in[0];
  assign headBit      = MSB_ORDER ? shiftReg[WIDTH-1] : shiftReg[0];
  assign nextBit      = MSB_ORDER ? shiftReg[WIDTH-2] : shiftReg[1];
  assign shiftNext    = MSB_ORDER ? (shiftReg << 1)   : (shiftReg >> 1);

  bit_tick_divider #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) symbolDivider (
    .clk   (clk),
    .reset (reset),
    .run   (frameActive),
    .tick  (symbolTick)
  );

  // Frame FSM: every output is registered, and each state change loads the
  // symbol for the next period so tx_d changes exactly on period boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_d      <= 1'b0;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
      shiftReg  <= '0;
      bitIdx    <= '0;
      parityReg <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start && tx_ready) begin
            shiftReg  <= data_in;
            parityReg <= parityBit(^data_in, PARITY);
            bitIdx    <= '0;
            tx_ready  <= 1'b0;
            if (HAS_FRAME) begin
              state <= ST_START;
              tx_d  <= 1'b1;
            end else begin
              state <= ST_DATA;
              tx_d  <= firstDataBit;
            end
          end
        end
        ST_START: begin
          if (symbolTick) begin
            state <= ST_DATA;
            tx_d  <= headBit;
          end
        end
        ST_DATA: begin
          if (symbolTick) begin
            if (bitIdx == LAST_IDX) begin
              if (HAS_PARITY) begin
                state <= ST_PARITY;
                tx_d  <= parityReg;
              end else if (HAS_FRAME) begin
                state <= ST_STOP;
                tx_d  <= 1'b0;
              end else begin
                state    <= ST_IDLE;
                tx_d     <= 1'b0;
                tx_ready <= 1'b1;
                tx_done  <= 1'b1;
              end
            end else begin
              bitIdx   <= bitIdx + IDX_W'(1);
              shiftReg <= shiftNext;
              tx_d     <= nextBit;
            end
          end
        end
        ST_PARITY: begin
          if (symbolTick) begin
            if (HAS_FRAME) begin
              state <= ST_STOP;
              tx_d  <= 1'b0;
            end else begin
              state    <= ST_IDLE;
              tx_d     <= 1'b0;
              tx_ready <= 1'b1;
              tx_done  <= 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (symbolTick) begin
            state    <= ST_IDLE;
            tx_d     <= 1'b0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_d     <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Testbench for frame_serializer: three differently configured instances are
// checked every cycle against a symbol-queue model of the frame format.
module tb_frame_serializer;

  logic       clk;
  logic       reset;
  logic       txStart [3];
  logic [7:0] dataIn  [3];
  logic       txReady [3];
  logic       txBusy  [3];
  logic       txD     [3];
  logic       txDone  [3];

  // Instance configurations: 0 = defaults, 1 = MSB/framed/even/DIV4,
  // 2 = LSB/framed/odd/DIV2.
  int cfgDiv    [3] = '{1, 4, 2};
  int cfgMsb    [3] = '{0, 1, 0};
  int cfgFramed [3] = '{0, 1, 1};
  int cfgPar    [3] = '{0, 1, 2};

  int checks = 0;
  int errors = 0;

  bit expQ [3][$];
  bit frameSyms [$];
  bit curD [3];
  bit curReady [3];
  bit curDone [3];
  bit modelValid = 0;

  frame_serializer dut0 (
    .clk(clk), .reset(reset), .tx_start(txStart[0]), .data_in(dataIn[0]),
    .tx_ready(txReady[0]), .tx_busy(txBusy[0]), .tx_d(txD[0]), .tx_done(txDone[0])
  );

  frame_serializer #(.DIV(4), .MSB_FIRST(1), .FRAMED(1), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .tx_start(txStart[1]), .data_in(dataIn[1]),
    .tx_ready(txReady[1]), .tx_busy(txBusy[1]), .tx_d(txD[1]), .tx_done(txDone[1])
  );

  frame_serializer #(.DIV(2), .MSB_FIRST(0), .FRAMED(1), .PARITY(2)) dut2 (
    .clk(clk), .reset(reset), .tx_start(txStart[2]), .data_in(dataIn[2]),
    .tx_ready(txReady[2]), .tx_busy(txBusy[2]), .tx_d(txD[2]), .tx_done(txDone[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Symbol list of one frame, straight from the frame format rules.
  function automatic void makeFrame(input int i, input logic [7:0] w);
    frameSyms.delete();
    if (cfgFramed[i] != 0) frameSyms.push_back(1'b1);
    for (int k = 0; k < 8; k++) frameSyms.push_back(cfgMsb[i] != 0 ? w[7-k] : w[k]);
    if (cfgPar[i] != 0) frameSyms.push_back((^w) ^ (cfgPar[i] == 2));
    if (cfgFramed[i] != 0) frameSyms.push_back(1'b0);
  endfunction

  function automatic logic [15:0] packSyms();
    logic [15:0] v;
    v = '0;
    foreach (frameSyms[k]) v = {v[14:0], frameSyms[k]};
    return v;
  endfunction

  // Reference model: on accept, the whole frame is expanded into a per-cycle
  // queue of expected tx_d values; the cycle after it drains is the done pulse.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        expQ[i].delete();
        curD[i] = 1'b0;
        curReady[i] = 1'b1;
        curDone[i] = 1'b0;
      end else begin
        if (curReady[i] && txStart[i]) begin
          makeFrame(i, dataIn[i]);
          foreach (frameSyms[k]) repeat (cfgDiv[i]) expQ[i].push_back(frameSyms[k]);
        end
        if (expQ[i].size() > 0) begin
          curD[i] = expQ[i].pop_front();
          curReady[i] = 1'b0;
          curDone[i] = 1'b0;
        end else if (!curReady[i]) begin
          curD[i] = 1'b0;
          curReady[i] = 1'b1;
          curDone[i] = 1'b1;
        end else begin
          curD[i] = 1'b0;
          curDone[i] = 1'b0;
        end
      end
    end
    if (reset) modelValid = 1'b1;
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("dut%0d.tx_d", i), 32'(txD[i]), 32'(curD[i]));
        checkOutput($sformatf("dut%0d.tx_ready", i), 32'(txReady[i]), 32'(curReady[i]));
        checkOutput($sformatf("dut%0d.tx_busy", i), 32'(txBusy[i]), 32'(!curReady[i]));
        checkOutput($sformatf("dut%0d.tx_done", i), 32'(txDone[i]), 32'(curDone[i]));
      end
    end
  end

  task automatic waitIdle(input int i);
    int n;
    n = 0;
    while (!curReady[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("idleWait%0d", i), 32'(curReady[i]), 32'h1);
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] w);
    waitIdle(i);
    txStart[i] = 1'b1;
    dataIn[i] = w;
    @(negedge clk);
    txStart[i] = 1'b0;
  endtask

  logic [7:0] cap;
  int cycles;
  bit seenDone;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txStart[i] = 1'b0;
      dataIn[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checkOutput("resetReady", 32'(txReady[0]), 32'h1);
    checkOutput("resetD", 32'(txD[0]), 32'h0);
    checkOutput("resetBusy", 32'(txBusy[1]), 32'h0);
    reset = 1'b0;

    // Hand-computed frames pin the model's symbol rules.
    makeFrame(0, 8'hA5);
    checkOutput("pinLsbA5", 32'(packSyms()), 32'h00A5);
    makeFrame(1, 8'h81);
    checkOutput("pinFramedEven81", 32'(packSyms()), 32'h0604);
    makeFrame(2, 8'h00);
    checkOutput("pinOdd00", 32'(packSyms()), 32'h0402);
    makeFrame(2, 8'hFF);
    checkOutput("pinOddFF", 32'(packSyms()), 32'h07FE);

    // Default config, literal serial pattern and done timing.
    @(negedge clk);
    txStart[0] = 1'b1;
    dataIn[0] = 8'hA5;
    @(negedge clk);
    txStart[0] = 1'b0;
    dataIn[0] = 8'h00;
    cap[0] = txD[0];
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      cap[k] = txD[0];
    end
    checkOutput("lsbFrameA5", 32'(cap), 32'h00A5);
    @(negedge clk);
    checkOutput("doneA5", 32'(txDone[0]), 32'h1);

    // Framed/parity/DIV=4 latency, with a tx_start pulse mid-frame.
    @(negedge clk);
    txStart[1] = 1'b1;
    dataIn[1] = 8'h81;
    cycles = 0;
    seenDone = 1'b0;
    while (!seenDone && cycles < 200) begin
      @(negedge clk);
      cycles++;
      txStart[1] = (cycles == 10);
      dataIn[1] = 8'($urandom);
      if (txDone[1]) seenDone = 1'b1;
    end
    txStart[1] = 1'b0;
    checkOutput("framedDoneLatency", 32'(cycles), 32'd45);

    // Odd parity on all-zeros and all-ones words.
    applyStimulus(2, 8'h00);
    applyStimulus(2, 8'hFF);
    waitIdle(2);

    // Back-to-back frames with tx_start held high.
    txStart[0] = 1'b1;
    dataIn[0] = 8'h0F;
    @(negedge clk);
    dataIn[0] = 8'hF0;
    cycles = 0;
    while (!curDone[0] && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2bGapLevel", 32'(txD[0]), 32'h0);
    @(negedge clk);
    txStart[0] = 1'b0;
    checkOutput("b2bSecondBusy", 32'(txBusy[0]), 32'h1);
    checkOutput("b2bSecondFirstBit", 32'(txD[0]), 32'h0);
    waitIdle(0);

    // Reset during symbol 3 aborts the frame without a done pulse.
    txStart[0] = 1'b1;
    dataIn[0] = 8'hC3;
    repeat (3) begin
      @(negedge clk);
      txStart[0] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortReady", 32'(txReady[0]), 32'h1);
    checkOutput("abortD", 32'(txD[0]), 32'h0);
    checkOutput("abortDone", 32'(txDone[0]), 32'h0);
    repeat (12) @(negedge clk);
    applyStimulus(0, 8'h3C);
    waitIdle(0);

    // data_in scrambled every cycle after accepting 8'h5A.
    txStart[0] = 1'b1;
    dataIn[0] = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      txStart[0] = 1'b0;
      dataIn[0] = 8'($urandom);
      cap[k] = txD[0];
    end
    checkOutput("dataHeld5A", 32'(cap), 32'h005A);
    waitIdle(0);

    // Random traffic on all instances, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(399) == 0);
      for (int i = 0; i < 3; i++) begin
        txStart[i] = ($urandom_range(2) == 0);
        dataIn[i] = 8'($urandom);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) txStart[i] = 1'b0;
    for (int i = 0; i < 3; i++) waitIdle(i);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
